change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Sequential stage directly downstream of the change-calculation logic.
- Accepts one transaction of up to two coins (first, then second) and dispenses them one at a time to a mechanical ejector over a valid/ack handshake.
- Owns the coin inventory registers and decrements them on each acknowledged ejection.
- Inventory counts are exported and fed back upstream as the available Pentagons/Triangles/Circles counts.

Parameters:
- INIT_P, 2'd3, pentagon count loaded at reset
- INIT_T, 2'd3, triangle count loaded at reset
- INIT_C, 2'd3, circle count loaded at reset
- TIMEOUT_CYCLES, 16, ack watchdog limit; used only with ACK_TIMEOUT_EN

Ports:
- clock  in  1  system clock, rising edge
- reset_L  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to dispense; sampled in IDLE only
- first_coin  in  3  coin code: 0 none, 1 circle, 3 triangle, 5 pentagon
- second_coin  in  3  coin code, same encoding
- load_inv  in  1  load inventory from load_* inputs; honoured in IDLE only
- load_p / load_t / load_c  in  2 each  inventory load values
- pentagons / triangles / circles  out  2 each  current inventory
- eject_valid  out  1  coin presented to ejector
- eject_coin  out  3  coin code being ejected; 0 when eject_valid=0
- eject_ack  in  1  ejector accepted the coin; sampled while eject_valid=1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: transaction complete
- error  out  1  one-cycle pulse: transaction rejected or aborted

Behaviour:
- Reset (async, reset_L=0): state=IDLE; eject_valid, eject_coin, busy, done, error = 0; inventory = INIT_P/T/C. Outputs drop immediately. Reset mid-transaction aborts with no done/error pulse.
- States: IDLE, EJECT1, EJECT2, DONE, ERR. All outputs are decoded from registered state and latched coins; no combinational path from inputs to outputs.
- IDLE, load_inv=1: inventory <= load_* on the next edge. start in the same cycle is ignored; load wins.
- IDLE, start=1: latch both coins, then validate.
  - Validation fails if either code is not in {0,1,3,5}, or if inventory is insufficient for the pair. Same type twice requires count >= 2.
  - Invalid -> ERR.
  - Both coins 0 -> DONE.
  - first coin 0 -> EJECT2.
  - Otherwise -> EJECT1.
- EJECT1: eject_valid=1, eject_coin=latched first. Holds stable until eject_ack=1.
  - On the ack edge: decrement that type's count by 1.
  - Next state: EJECT2 if second coin != 0, else DONE.
- EJECT2: same as EJECT1 for the second coin; on ack -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- ERR: error=1 for exactly one cycle, inventory unchanged -> IDLE.
- eject_ack outside EJECT states is ignored. start while busy is ignored, not queued. load_inv while busy is ignored.
- Latency with ack tied high: start at cycle t; eject_valid at t+1; second coin at t+2; done at t+3. Single-coin transaction: done at t+2. Zero-coin transaction: done at t+1. Rejected transaction: error at t+1.
- Inventory is 2-bit, 0..3. Pre-check guarantees no underflow. Counts never wrap.

Optional Feature:
- Macro ACK_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to EJECT1/EJECT2 and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES without ack: go to ERR. Coins already acknowledged stay decremented; the un-acked coin is not decremented.
  - An ack arriving on the same cycle the count hits the limit wins; the coin is counted as ejected.
- Undefined: no counter; EJECT states wait indefinitely for ack.

Test Plan:
- Reset, inventory 3/3/3; start, first=5, second=3, ack tied high -> eject_coin 5 at t+1, 3 at t+2, done at t+3; inventory 2/2/3.
- load_inv with 0/1/1; start, first=3, second=3 -> error pulse at t+1; no eject_valid; inventory stays 0/1/1.
- start, first=1, second=1, ack delayed 4 cycles each -> eject_valid and eject_coin=1 held stable throughout; circles 3->1; done once.
- start, first=0, second=0 -> done at t+1, no eject_valid; start with first=2 -> error, no change. start and load_inv in the same cycle -> load applied, no transaction.
- reset_L low while in EJECT2 -> eject_valid drops the same cycle; inventory returns to 3/3/3; no done/error pulse.
- ACK_TIMEOUT_EN, TIMEOUT_CYCLES=16: first=5, ack never asserted -> error 16 cycles after eject_valid rises; pentagons unchanged.

Source files
------------

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - two-coin dispenser with inventory and ejector valid/ack handshake
// Optional ack watchdog: define ACK_TIMEOUT_EN.
module change_dispenser #(
  parameter logic [1:0] INIT_P         = 2'd3,
  parameter logic [1:0] INIT_T         = 2'd3,
  parameter logic [1:0] INIT_C         = 2'd3,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       start,
  input  logic [2:0] first_coin,
  input  logic [2:0] second_coin,
  input  logic       load_inv,
  input  logic [1:0] load_p,
  input  logic [1:0] load_t,
  input  logic [1:0] load_c,
  output logic [1:0] pentagons,
  output logic [1:0] triangles,
  output logic [1:0] circles,
  output logic       eject_valid,
  output logic [2:0] eject_coin,
  input  logic       eject_ack,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] COIN_NONE = 3'd0;
  localparam logic [2:0] COIN_C    = 3'd1;
  localparam logic [2:0] COIN_T    = 3'd3;
  localparam logic [2:0] COIN_P    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EJECT1 = 3'd1,
    S_EJECT2 = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] coin1, coin2;
  logic [2:0] cur_coin;
  logic       in_eject;
  logic       accept;
  logic       take_start;
  logic       req_ok;
  logic       timeout_hit;
  logic [1:0] need_p, need_t, need_c;

  function automatic logic code_ok(input logic [2:0] c);
    return (c == COIN_NONE) || (c == COIN_C) || (c == COIN_T) || (c == COIN_P);
  endfunction

  assign in_eject   = (state == S_EJECT1) || (state == S_EJECT2);
  assign cur_coin   = (state == S_EJECT1) ? coin1 : coin2;
  assign accept     = in_eject && eject_ack;
  // load_inv has priority over start in IDLE
  assign take_start = (state == S_IDLE) && start && !load_inv;

  // Per-type demand of the requested pair, checked against current stock
  assign need_p = {1'b0, first_coin == COIN_P} + {1'b0, second_coin == COIN_P};
  assign need_t = {1'b0, first_coin == COIN_T} + {1'b0, second_coin == COIN_T};
  assign need_c = {1'b0, first_coin == COIN_C} + {1'b0, second_coin == COIN_C};
  assign req_ok = code_ok(first_coin) && code_ok(second_coin) &&
                  (need_p <= pentagons) && (need_t <= triangles) && (need_c <= circles);

`ifdef ACK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  // Watchdog: cleared on every state change, counts ack-less cycles in EJECT states
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      to_cnt <= '0;
    end else if (state_nxt != state) begin
      to_cnt <= '0;
    end else if (in_eject && !eject_ack) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  // Limit is reached on this edge; a coincident ack takes precedence
  assign timeout_hit = in_eject && !eject_ack && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog the EJECT states wait for ack indefinitely
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // State register
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (take_start) begin
          if (!req_ok)                                         state_nxt = S_ERR;
          else if (first_coin == COIN_NONE && second_coin == COIN_NONE) state_nxt = S_DONE;
          else if (first_coin == COIN_NONE)                    state_nxt = S_EJECT2;
          else                                                 state_nxt = S_EJECT1;
        end
      end
      S_EJECT1: begin
        if (eject_ack)        state_nxt = (coin2 != COIN_NONE) ? S_EJECT2 : S_DONE;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_EJECT2: begin
        if (eject_ack)        state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state and latched coins
  always_comb begin
    eject_valid = in_eject;
    eject_coin  = in_eject ? cur_coin : COIN_NONE;
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    error       = (state == S_ERR);
  end

  // Latch the requested pair when a transaction is accepted
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      coin1 <= COIN_NONE;
      coin2 <= COIN_NONE;
    end else if (take_start) begin
      coin1 <= first_coin;
      coin2 <= second_coin;
    end
  end

  // Inventory: load in IDLE, decrement on each acknowledged ejection
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      pentagons <= INIT_P;
      triangles <= INIT_T;
      circles   <= INIT_C;
    end else if (state == S_IDLE && load_inv) begin
      pentagons <= load_p;
      triangles <= load_t;
      circles   <= load_c;
    end else if (accept) begin
      case (cur_coin)
        COIN_P:  pentagons <= pentagons - 2'd1;
        COIN_T:  triangles <= triangles - 2'd1;
        COIN_C:  circles   <= circles - 2'd1;
        default: ;
      endcase
    end
  end

endmodule
